// File: rtl/uart_tx_arbiter_pkg.sv
// Shared state encoding, default limits and sizing helper for the UART TX arbiter.
package uart_tx_arbiter_pkg;

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } state_e;

   localparam int DEF_MAX_BURST = 16;
   localparam int DEF_IDLE_TO   = 32;

   function automatic int id_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first valid index after last_grant, wrapping.
module uart_tx_arbiter_rr_pick import uart_tx_arbiter_pkg::*; #(
   parameter  int NUM_REQ = 4,
   localparam int ID_W    = id_width(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req_valid,
   input  logic [ID_W-1:0]    last_grant,
   output logic [ID_W-1:0]    pick_idx,
   output logic               pick_any
);

   logic [ID_W-1:0] hi_idx;
   logic [ID_W-1:0] lo_idx;
   logic            hi_any;
   logic            lo_any;

   // Descending scan leaves the lowest match; "hi" only sees indices above last_grant.
   always_comb begin
      hi_idx = '0;
      lo_idx = '0;
      hi_any = 1'b0;
      lo_any = 1'b0;
      for (int j = NUM_REQ - 1; j >= 0; j--) begin
         if (req_valid[j]) begin
            lo_any = 1'b1;
            lo_idx = ID_W'(j);
            if (ID_W'(j) > last_grant) begin
               hi_any = 1'b1;
               hi_idx = ID_W'(j);
            end
         end
      end
   end

   assign pick_any = lo_any;
   assign pick_idx = hi_any ? hi_idx : lo_idx;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing the TX FIFO write port between byte producers.
module uart_tx_arbiter import uart_tx_arbiter_pkg::*; #(
   parameter  int NUM_REQ   = 4,
   parameter  int DATA_W    = 8,
   parameter  int MAX_BURST = DEF_MAX_BURST,
   parameter  int IDLE_TO   = DEF_IDLE_TO,
   localparam int ID_W      = id_width(NUM_REQ)
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ*DATA_W-1:0] req_data,
   input  logic [NUM_REQ-1:0]        req_last,
   output logic [NUM_REQ-1:0]        req_ready,
   input  logic                      fifo_full,
   output logic                      fifo_wr_en,
   output logic [DATA_W-1:0]         fifo_din,
   output logic                      grant_valid,
   output logic [ID_W-1:0]           grant_id,
   output logic                      timeout_pulse
);

   localparam int BEAT_W = $clog2(MAX_BURST + 1);
   localparam int IDLE_W = $clog2(IDLE_TO + 1);
   localparam logic [BEAT_W-1:0] BEAT_LIMIT = BEAT_W'(MAX_BURST - 1);
   localparam logic [IDLE_W-1:0] IDLE_LIMIT = IDLE_W'(IDLE_TO - 1);

   state_e              state_q, state_d;
   logic [ID_W-1:0]     last_grant_q, last_grant_d;
   logic [ID_W-1:0]     grant_id_q, grant_id_d;
   logic                grant_valid_q, grant_valid_d;
   logic                timeout_pulse_q, timeout_pulse_d;
   logic [BEAT_W-1:0]   beat_cnt_q, beat_cnt_d;
   logic [IDLE_W-1:0]   idle_cnt_q, idle_cnt_d;

   logic [ID_W-1:0]     pick_idx;
   logic                pick_any;
   logic                granted;
   logic                sel_valid;
   logic                sel_last;
   logic [DATA_W-1:0]   sel_data;
   logic                accept;

   uart_tx_arbiter_rr_pick #(
      .NUM_REQ (NUM_REQ)
   ) u_rr_pick (
      .req_valid  (req_valid),
      .last_grant (last_grant_q),
      .pick_idx   (pick_idx),
      .pick_any   (pick_any)
   );

   // Reset gates the datapath so a byte in flight is never written while reset is high.
   always_comb begin
      granted   = (state_q == ST_GRANT) && !reset;
      sel_valid = 1'b0;
      sel_last  = 1'b0;
      sel_data  = '0;
      req_ready = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant_id_q == ID_W'(i)) begin
            sel_valid    = req_valid[i];
            sel_last     = req_last[i];
            sel_data     = req_data[i*DATA_W +: DATA_W];
            req_ready[i] = granted && !fifo_full;
         end
      end
      accept     = granted && sel_valid && !fifo_full;
      fifo_wr_en = accept;
      fifo_din   = accept ? sel_data : '0;
   end

   always_comb begin
      state_d         = state_q;
      last_grant_d    = last_grant_q;
      grant_id_d      = grant_id_q;
      grant_valid_d   = grant_valid_q;
      beat_cnt_d      = beat_cnt_q;
      idle_cnt_d      = idle_cnt_q;
      timeout_pulse_d = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (pick_any) begin
               state_d       = ST_GRANT;
               grant_id_d    = pick_idx;
               grant_valid_d = 1'b1;
               beat_cnt_d    = '0;
               idle_cnt_d    = '0;
            end
         end
         ST_GRANT: begin
            if (accept) begin
               beat_cnt_d = beat_cnt_q + BEAT_W'(1);
               idle_cnt_d = '0;
               if (sel_last || (beat_cnt_q == BEAT_LIMIT)) begin
                  state_d       = ST_IDLE;
                  grant_valid_d = 1'b0;
                  last_grant_d  = grant_id_q;
               end
            end else if (!sel_valid && !fifo_full) begin
               // Stall cycles with the FIFO full never age the grant.
               if (idle_cnt_q == IDLE_LIMIT) begin
                  state_d         = ST_IDLE;
                  grant_valid_d   = 1'b0;
                  last_grant_d    = grant_id_q;
                  timeout_pulse_d = 1'b1;
               end else begin
                  idle_cnt_d = idle_cnt_q + IDLE_W'(1);
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q         <= ST_IDLE;
         last_grant_q    <= ID_W'(NUM_REQ - 1);
         grant_id_q      <= '0;
         grant_valid_q   <= 1'b0;
         timeout_pulse_q <= 1'b0;
         beat_cnt_q      <= '0;
         idle_cnt_q      <= '0;
      end else begin
         state_q         <= state_d;
         last_grant_q    <= last_grant_d;
         grant_id_q      <= grant_id_d;
         grant_valid_q   <= grant_valid_d;
         timeout_pulse_q <= timeout_pulse_d;
         beat_cnt_q      <= beat_cnt_d;
         idle_cnt_q      <= idle_cnt_d;
      end
   end

   assign grant_valid   = grant_valid_q;
   assign grant_id      = grant_id_q;
   assign timeout_pulse = timeout_pulse_q;

endmodule
